// File: rtl/soc_sim_pkg.sv
// ----------------------------------------------------------------------------
// soc_sim_pkg
// Shared types and helpers for the SoC end-of-test signature monitor.
//   end_cause_e    : why the run ended (none / trap / EOT write / timeout)
//   state_e        : monitor FSM states (RUN -> CHECK -> DONE)
//   SIG_MAGIC_PASS : value firmware writes to a signature word on success
//   merge_bytes    : byte-strobe merge of a new word into an old word
// ----------------------------------------------------------------------------
package soc_sim_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TRAP    = 2'd1,
    CAUSE_EOT     = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } end_cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [31:0] SIG_MAGIC_PASS = 32'hCAFE_0001;

  // Replace only the bytes whose strobe bit is set; the others keep old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sig_capture_bank.sv
// ----------------------------------------------------------------------------
// sig_capture_bank
// NUM_SIGS x 32-bit shadow copies of the firmware signature words.
// Ports:
//   clk    : system clock
//   clr    : synchronous clear of every shadow word
//   we     : write enable (already qualified as an in-window write transfer)
//   idx    : shadow word index
//   wstrb  : byte enables; unstrobed bytes keep their value
//   wdata  : write data
//   shadow : packed shadow words, word i at shadow[32*i +: 32]
// ----------------------------------------------------------------------------
module sig_capture_bank
  import soc_sim_pkg::*;
#(
  parameter int NUM_SIGS = 32'd4,
  parameter int IDX_W    = 32'd2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              wdata,
  output logic [NUM_SIGS*32-1:0]   shadow
);

  // Shadow word storage: clear, or byte-merge into the addressed word.
  always_ff @(posedge clk) begin
    if (clr) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_SIGS; i++) begin
        if (we && (idx == IDX_W'(i))) begin
          shadow[32*i +: 32] <= merge_bytes(shadow[32*i +: 32], wdata, wstrb);
        end
      end
    end
  end

endmodule

// File: rtl/soc_sig_monitor.sv
// ----------------------------------------------------------------------------
// soc_sig_monitor
// End-of-test monitor for the PicoRV32+TPU SoC. Snoops the native memory bus,
// shadows firmware writes to NUM_SIGS signature words, ends the run on trap,
// an EOT register write or a cycle timeout, then latches a pass/fail verdict.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   mem_valid/ready          : bus handshake, transfer when both high
//   mem_addr/wdata/wstrb     : bus address, write data, byte enables (0 = read)
//   trap                     : CPU trap
//   done                     : verdict valid, sticky until rst
//   pass                     : all signatures match and run did not time out
//   timed_out                : run ended by timeout
//   end_cause                : 0 none, 1 trap, 2 EOT write, 3 timeout
//   mismatch                 : per-word compare failure
//   eot_code                 : data of the last EOT write
//   cycles                   : cycles spent in RUN, saturating
// ----------------------------------------------------------------------------
module soc_sig_monitor
  import soc_sim_pkg::*;
#(
  parameter logic [31:0]            SIG_BASE = 32'h0000_3F00,
  parameter int                     NUM_SIGS = 32'd4,
  parameter logic [NUM_SIGS*32-1:0] EXPECT   = {NUM_SIGS{SIG_MAGIC_PASS}},
  parameter logic [31:0]            EOT_ADDR = 32'h0000_3FFC,
  parameter int unsigned            TIMEOUT  = 32'd200000,
  parameter int                     CNT_W    = 32'd32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid,
  input  logic                mem_ready,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  input  logic                trap,
  output logic                done,
  output logic                pass,
  output logic                timed_out,
  output logic [1:0]          end_cause,
  output logic [NUM_SIGS-1:0] mismatch,
  output logic [31:0]         eot_code,
  output logic [CNT_W-1:0]    cycles
);

  localparam int              IDX_W        = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1;
  localparam bit              TIMEOUT_EN   = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_e                state_r;
  end_cause_e            cause_r;
  end_cause_e            cause_s;
  logic                  wr_s;
  logic                  eot_wr_s;
  logic                  in_win_s;
  logic                  sig_we_s;
  logic [32:0]           sig_off_s;
  logic [NUM_SIGS-1:0]   mismatch_s;
  logic [NUM_SIGS*32-1:0] shadow_s;
  logic                  unused_addr_s;

  // Byte offset bits carry no meaning for word-wide capture.
  assign unused_addr_s = ^mem_addr[1:0];

  assign wr_s     = mem_valid & mem_ready & (mem_wstrb != 4'b0000);
  assign eot_wr_s = wr_s & (mem_addr[31:2] == EOT_ADDR[31:2]);

  // 33-bit word offset: an address below SIG_BASE borrows into bit 32
  // instead of wrapping into a small positive offset.
  assign sig_off_s = {3'b000, mem_addr[31:2]} - {3'b000, SIG_BASE[31:2]};
  assign in_win_s  = ~sig_off_s[32] & (sig_off_s < 33'(NUM_SIGS));
  assign sig_we_s  = (state_r == ST_RUN) & wr_s & in_win_s;

  assign end_cause = cause_r;

  sig_capture_bank #(
    .NUM_SIGS (NUM_SIGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .clk    (clk),
    .clr    (rst),
    .we     (sig_we_s),
    .idx    (sig_off_s[IDX_W-1:0]),
    .wstrb  (mem_wstrb),
    .wdata  (mem_wdata),
    .shadow (shadow_s)
  );

  // End-event arbitration: trap beats EOT beats timeout.
  always_comb begin
    cause_s = CAUSE_NONE;
    if (trap) begin
      cause_s = CAUSE_TRAP;
    end else if (eot_wr_s) begin
      cause_s = CAUSE_EOT;
    end else if (TIMEOUT_EN && (cycles == TIMEOUT_LAST)) begin
      cause_s = CAUSE_TIMEOUT;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Per-word signature compare against the expected values.
  always_comb begin
    mismatch_s = '0;
    for (int i = 0; i < NUM_SIGS; i++) begin
      mismatch_s[i] = (shadow_s[32*i +: 32] != EXPECT[32*i +: 32]);
    end
  end

  // Run / check / done sequencing and the registered verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      cause_r   <= CAUSE_NONE;
      cycles    <= '0;
      eot_code  <= 32'h0000_0000;
      mismatch  <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cycles != {CNT_W{1'b1}}) begin
            cycles <= cycles + CNT_W'(32'd1);
          end
          // Captured on any EOT write, even when a trap wins the cause.
          if (eot_wr_s) begin
            eot_code <= mem_wdata;
          end
          if (cause_s != CAUSE_NONE) begin
            cause_r <= cause_s;
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          mismatch  <= mismatch_s;
          done      <= 1'b1;
          pass      <= (mismatch_s == '0) && (cause_r != CAUSE_TIMEOUT);
          timed_out <= (cause_r == CAUSE_TIMEOUT);
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_sig_monitor.sv
// ----------------------------------------------------------------------------
// tb_soc_sig_monitor
// Directed bench for soc_sig_monitor. A behavioural model tracks the run
// (elapsed cycles, captured signature words, end cause, EOT data) and a
// negedge process compares the DUT against it every cycle; directed literal
// checks pin the model to hand-computed values. A second instance with
// TIMEOUT=0 covers the disabled-timeout case.
// ----------------------------------------------------------------------------
module tb_soc_sig_monitor;

  localparam logic [31:0] SIG_BASE = 32'h0000_3F00;
  localparam logic [31:0] EOT_ADDR = 32'h0000_3FFC;
  localparam logic [31:0] MAGIC    = 32'hCAFE_0001;
  localparam int          TMO      = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr  = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        trap = 1'b0;

  logic        done, pass, timed_out;
  logic [1:0]  end_cause;
  logic [3:0]  mismatch;
  logic [31:0] eot_code, cycles;

  logic        done_nt, pass_nt, timed_out_nt;
  logic [1:0]  end_cause_nt;
  logic [3:0]  mismatch_nt;
  logic [31:0] eot_code_nt, cycles_nt;

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;   // clock edges since reset release

  soc_sig_monitor #(.NUM_SIGS(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .trap(trap),
    .done(done), .pass(pass), .timed_out(timed_out), .end_cause(end_cause),
    .mismatch(mismatch), .eot_code(eot_code), .cycles(cycles)
  );

  soc_sig_monitor #(.NUM_SIGS(4), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .trap(trap),
    .done(done_nt), .pass(pass_nt), .timed_out(timed_out_nt), .end_cause(end_cause_nt),
    .mismatch(mismatch_nt), .eot_code(eot_code_nt), .cycles(cycles_nt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_sig [4];
  logic [31:0] m_eot;
  bit          m_ok = 1'b0;
  bit          m_run;
  bit          m_wr, m_eotw;
  int          m_k, m_since, m_cause, m_idx;
  longint      m_off;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_run = 1'b1; m_k = 0; m_since = 0; m_cause = 0; m_eot = 32'h0;
      for (int i = 0; i < 4; i++) m_sig[i] = 32'h0;
    end else if (m_run) begin
      m_wr   = mem_valid && mem_ready && (mem_wstrb != 4'b0000);
      m_eotw = m_wr && (mem_addr[31:2] == EOT_ADDR[31:2]);
      m_off  = longint'(mem_addr[31:2]) - longint'(SIG_BASE[31:2]);
      if (m_wr && m_off >= 0 && m_off < 4) begin
        m_idx = int'(m_off);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) m_sig[m_idx][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      if (m_eotw) m_eot = mem_wdata;
      if (trap) m_cause = 1;
      else if (m_eotw) m_cause = 2;
      else if (TMO != 0 && m_k == TMO - 1) m_cause = 3;
      else m_cause = 0;
      m_k++;                      // this RUN cycle is counted, ending or not
      if (m_cause != 0) begin
        m_run = 1'b0; m_since = 0;
      end
    end else begin
      m_since++;
    end
  end

  logic [3:0] exp_mm;
  bit         exp_done;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 4; i++) exp_mm[i] = (m_sig[i] != MAGIC);
      exp_done = !m_run && (m_since >= 1);
      check("done", done, exp_done);
      check("pass", pass, exp_done && (exp_mm == 4'b0) && (m_cause != 3));
      check("timed_out", timed_out, exp_done && (m_cause == 3));
      check("cycles", cycles, m_k);
      if (exp_done) begin
        check("end_cause", end_cause, m_cause);
        check("eot_code", eot_code, m_eot);
        check("mismatch", mismatch, exp_mm);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cur++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_ready = 1'b0; mem_wstrb = 4'h0; trap = 1'b0;
    step(2);
    rst = 1'b0;
    cur = 0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit rdy);
    mem_valid = 1'b1; mem_ready = rdy; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    step(1);
    mem_valid = 1'b0; mem_ready = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic write_all_sigs();
    for (int i = 0; i < 4; i++) xfer(SIG_BASE + 32'(4 * i), MAGIC, 4'hF, 1'b1);
  endtask

  task automatic wait_until(input int c);
    while (cur < c) step(1);
  endtask

  task automatic pulse_trap();
    trap = 1'b1; step(1); trap = 1'b0;
  endtask

  task automatic bytewise_run(input bit skip3);
    do_reset();
    xfer(SIG_BASE + 32'd0,  MAGIC, 4'hF, 1'b1);
    xfer(SIG_BASE + 32'd4,  MAGIC, 4'hF, 1'b1);
    xfer(SIG_BASE + 32'd12, MAGIC, 4'hF, 1'b1);
    xfer(SIG_BASE + 32'd8,  MAGIC, 4'b0001, 1'b1);
    xfer(SIG_BASE + 32'd9,  MAGIC, 4'b0010, 1'b1);   // low address bits are don't-care
    xfer(SIG_BASE + 32'd10, MAGIC, 4'b0100, 1'b1);
    if (!skip3) xfer(SIG_BASE + 32'd11, MAGIC, 4'b1000, 1'b1);
    pulse_trap();
    step(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    check("rst_done", done, 1'b0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_cause", end_cause, 2'd0);
    check("rst_eot", eot_code, 32'd0);
    check("rst_mismatch", mismatch, 4'd0);

    // 1: all signatures, trap sampled on edge 50
    write_all_sigs();
    wait_until(49);
    pulse_trap();
    check("t1_not_done_in_check", done, 1'b0);
    step(1);
    check("t1_done", done, 1'b1);
    check("t1_pass", pass, 1'b1);
    check("t1_cause", end_cause, 2'd1);
    check("t1_mismatch", mismatch, 4'd0);
    check("t1_cycles", cycles, 32'd50);

    // 2: byte-wise word 2, complete and with byte 3 missing
    bytewise_run(1'b0);
    check("t2a_pass", pass, 1'b1);
    bytewise_run(1'b1);
    check("t2b_pass", pass, 1'b0);
    check("t2b_mismatch", mismatch, 4'b0100);

    // 3: timeout with correct signatures still fails
    do_reset();
    write_all_sigs();
    wait_until(1000);
    check("t3_not_done_1000", done, 1'b0);
    step(1);
    check("t3_done_1001", done, 1'b1);
    check("t3_timed_out", timed_out, 1'b1);
    check("t3_cause", end_cause, 2'd3);
    check("t3_pass", pass, 1'b0);
    check("t3_cycles", cycles, 32'd1000);

    // 4a: EOT write with a single strobe still records the full word
    do_reset();
    xfer(EOT_ADDR, 32'h0000_0042, 4'b0001, 1'b1);
    step(1);
    check("t4a_cause", end_cause, 2'd2);
    check("t4a_eot", eot_code, 32'h0000_0042);
    check("t4a_pass", pass, 1'b0);
    // 4b: trap and EOT together -> trap wins
    do_reset();
    write_all_sigs();
    trap = 1'b1;
    xfer(EOT_ADDR, 32'h0000_0007, 4'hF, 1'b1);
    trap = 1'b0;
    step(1);
    check("t4b_cause", end_cause, 2'd1);
    check("t4b_pass", pass, 1'b1);

    // 5: ignored traffic, then activity after done
    do_reset();
    write_all_sigs();
    xfer(SIG_BASE,          32'hDEAD_BEEF, 4'h0, 1'b1);  // read
    xfer(SIG_BASE - 32'd4,  32'hDEAD_BEEF, 4'hF, 1'b1);  // just below window
    xfer(SIG_BASE + 32'd16, 32'hDEAD_BEEF, 4'hF, 1'b1);  // just above window
    xfer(SIG_BASE + 32'd4,  32'hDEAD_BEEF, 4'hF, 1'b0);  // no ready, no transfer
    pulse_trap();
    step(1);
    check("t5_pass", pass, 1'b1);
    check("t5_cycles", cycles, 32'd9);
    xfer(SIG_BASE, 32'h1234_5678, 4'hF, 1'b1);
    xfer(EOT_ADDR, 32'h0000_0099, 4'hF, 1'b1);
    pulse_trap();
    step(3);
    check("t5_after_pass", pass, 1'b1);
    check("t5_after_cause", end_cause, 2'd1);
    check("t5_after_eot", eot_code, 32'd0);
    check("t5_after_cycles", cycles, 32'd9);

    // 6: reset mid-run, then a fresh passing run
    do_reset();
    xfer(SIG_BASE, MAGIC, 4'hF, 1'b1);
    xfer(EOT_ADDR - 32'd0, 32'h0, 4'h0, 1'b1);           // read of EOT, ignored
    wait_until(20);
    check("t6_cycles_20", cycles, 32'd20);
    rst = 1'b1;
    step(1);
    check("t6_rst_cycles", cycles, 32'd0);
    check("t6_rst_done", done, 1'b0);
    check("t6_rst_cause", end_cause, 2'd0);
    do_reset();
    write_all_sigs();
    pulse_trap();
    step(1);
    check("t6_fresh_pass", pass, 1'b1);
    check("t6_fresh_cycles", cycles, 32'd5);

    // 6b: disabled timeout runs 5000 cycles without ending
    do_reset();
    step(5000);
    check("t6_nt_done", done_nt, 1'b0);
    check("t6_nt_timed_out", timed_out_nt, 1'b0);
    check("t6_nt_cycles", cycles_nt, 32'd5000);
    check("t6_tmo_timed_out", timed_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
